// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped BTB with a 2-bit saturating direction counter per entry.
//   It supplies the fall-back next-PC for fetch.
//   Lookup is combinational from pc_if.
//   Training happens on the rising edge from branches resolved in EX.
//
// Optional feature macro: BP_STATS_EN
//   When defined, stat_updates and stat_mispredicts are live 32-bit
//   wrapping counters.
//   When undefined, both ports are tied to zero and no counter flops exist.
//
// Ports
//   clk              core clock, rising-edge
//   rst_n            asynchronous active-low reset
//   pc_if            PC being fetched
//   predict_target   predicted next PC (BTB target or pc_if+4)
//   predict_taken    lookup hit with counter in a taken state
//   upd_valid        EX resolved a br/jal/jalr this cycle
//   upd_pc           PC of the resolved instruction
//   upd_taken        actual direction
//   upd_target       actual taken target
//   upd_pred_taken   direction that IF predicted for this instruction
//   stat_updates     number of updates seen
//   stat_mispredicts number of direction mispredicts seen
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_if,
  output logic [31:0] predict_target,
  output logic        predict_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  // Lookup (reads pre-edge contents; no write-to-read bypass)
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [31:0]      pc_plus4;

  assign lk_idx   = pc_if[IDX_W+1:2];
  assign lk_tag   = pc_if[31:IDX_W+2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pc_plus4 = pc_if + 32'd4;

  assign predict_taken  = lk_hit && ctr_q[lk_idx][1];
  assign predict_target = predict_taken ? target_q[lk_idx] : pc_plus4;

  // Update
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
        end else begin
          if (ctr_q[up_idx] != 2'b00) ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target carry no reset; valid_q guards them.
  // On a hit the tag rewrite is a no-op.
  // Taken always refreshes the target, and a miss-taken allocates.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] n_upd_q;
  logic [31:0] n_mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_upd_q <= '0;
      n_mis_q <= '0;
    end else if (upd_valid) begin
      n_upd_q <= n_upd_q + 32'd1;
      if (upd_taken != upd_pred_taken) n_mis_q <= n_mis_q + 32'd1;
    end
  end

  assign stat_updates     = n_upd_q;
  assign stat_mispredicts = n_mis_q;

  logic unused_bits;
  assign unused_bits = ^upd_pc[1:0];
`else
  assign stat_updates     = 32'h0;
  assign stat_mispredicts = 32'h0;

  logic unused_bits;
  assign unused_bits = ^{upd_pc[1:0], upd_pred_taken};
`endif

endmodule
